wb_timer_slave: RTL

//  Wishbone classic (B3, non-pipelined) slave front-end for the timer register block.

---
 rtl/wb_timer_slave.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/wb_timer_slave.sv
// wb_timer_slave: Wishbone classic (B3) slave front-end for one timer register block.
// Decodes a 16-byte window at BASE_ADDR and drives the timer's simple register port.
// Partial-width writes are merged with the current register value by read-modify-write.
// Read data is registered; every accepted transfer ends with a one-cycle ack (or err).
// Optional feature macro: WB_ERR_EN -- when defined, unmapped accesses and writes to
// read-only registers terminate with wb_err_o instead of wb_ack_o.
module wb_timer_slave #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h4000_0000,
    parameter int                NUM_REGS  = 3,
    parameter logic [3:0]        RO_MASK   = 4'b0100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              reg_we,
    output logic [1:0]        reg_addr,
    output logic [31:0]       reg_din,
    input  logic [31:0]       reg_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_MERGE,
        S_RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    // Attributes of the request being serviced, latched when it is accepted.
    logic       req_we;
    logic       req_bad;
    logic [3:0] req_sel;

    // Byte offset bits are irrelevant to a word-only register block.
    logic unused_adr_bits;
    assign unused_adr_bits = ^wb_adr_i[1:0];

    // Request decode on the live bus signals (only meaningful in IDLE).
    logic [1:0] adr_idx;
    logic       req_hit;
    logic       adr_bad;

    assign adr_idx = wb_adr_i[3:2];
    assign req_hit = wb_cyc_i && wb_stb_i
                  && (wb_adr_i[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
    assign adr_bad = (int'(adr_idx) >= NUM_REGS) || (wb_we_i && RO_MASK[adr_idx]);

    // Classification of the latched request.
    logic sel_full;
    logic sel_none;
    logic sel_part;
    logic write_ok;

    assign sel_full = (req_sel == 4'hF);
    assign sel_none = (req_sel == 4'h0);
    assign sel_part = !sel_full && !sel_none;
    assign write_ok = req_we && !req_bad;

    // Byte-lane merge: selected lanes take the new data, others keep the old value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] new_val,
                                                input logic [31:0] old_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments only, so every
        // flop samples pre-edge values regardless of process evaluation order.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; dropping cyc during ACCESS/MERGE abandons the transfer.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_nxt
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            S_IDLE:   if (req_hit) state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (!wb_cyc_i)                 state_nxt = S_IDLE;
                else if (write_ok && sel_part) state_nxt = S_MERGE;
                else                           state_nxt = S_RESP;
            end
            S_MERGE:  state_nxt = wb_cyc_i ? S_RESP : S_IDLE;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register: write strobe, ack and err pulses.
    always_comb begin
        reg_we   = ((state == S_ACCESS) && write_ok && sel_full) || (state == S_MERGE);
`ifdef WB_ERR_EN
        wb_ack_o = (state == S_RESP) && !req_bad;
        wb_err_o = (state == S_RESP) &&  req_bad;
`else
        wb_ack_o = (state == S_RESP);
        wb_err_o = 1'b0;
`endif
    end

    // Datapath: latch the request, capture read data, build the merged write word.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_we   <= 1'b0;
            req_bad  <= 1'b0;
            req_sel  <= 4'h0;
            reg_addr <= 2'd0;
            reg_din  <= 32'h0;
            wb_dat_o <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_hit) begin
                        req_we   <= wb_we_i;
                        req_bad  <= adr_bad;
                        req_sel  <= wb_sel_i;
                        reg_addr <= adr_idx;
                        reg_din  <= wb_dat_i;
                    end
                end
                S_ACCESS: begin
                    if (wb_cyc_i) begin
                        if (!req_we) begin
                            if (!req_bad) begin
                                wb_dat_o <= reg_dout;
                            end else begin
`ifndef WB_ERR_EN
                                wb_dat_o <= 32'h0;
`endif
                            end
                        end else if (write_ok && sel_part) begin
                            // reg_din still holds the bus write data at this point.
                            reg_din <= merge_bytes(reg_din, reg_dout, req_sel);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
